// File: rtl/inp_capture_if.sv
// Valid/ack handshake carrying one captured 16-bit operator entry to the processor.
interface inp_capture_if;
    logic [15:0] inpval;
    logic        inpvalid;
    logic        inack;

    modport master (output inpval, output inpvalid, input inack);
    modport slave  (input inpval, input inpvalid, output inack);
endinterface

// File: rtl/inp_capture.sv
// Switch-bank input capture: 2-flop synchronisers, debounced enter button, and a
// valid/ack holder; `define INP_CAPTURE_FIFO_EN swaps the holder for a 4-entry FIFO.
module inp_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [15:0]         sw,
    input  logic                n_enter,
    output logic [15:0]         live,
    output logic                overrun,
    inp_capture_if.master       bus
);
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

    logic [DATA_W-1:0] sw_s1;
    logic              en_s1, en_s2;
    logic              pressed;
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              capture;
    logic              cnt_done;

    // Synchronisers: n_enter idles high (released) out of reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_s1 <= '0;
            live  <= '0;
            en_s1 <= 1'b1;
            en_s2 <= 1'b1;
        end else begin
            sw_s1 <= sw;
            live  <= sw_s1;
            en_s1 <= n_enter;
            en_s2 <= en_s1;
        end
    end

    assign pressed  = ~en_s2;
    assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Debounce FSM: one capture per press, full debounced release required before the next
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        unique case (state)
            IDLE: if (pressed) begin
                state_nxt = ARM;
                cnt_nxt   = '0;
            end
            ARM: if (!pressed) begin
                state_nxt = IDLE;
            end else if (cnt_done) begin
                capture   = 1'b1;
                state_nxt = HELD;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
            HELD: if (!pressed) begin
                state_nxt = REL;
                cnt_nxt   = '0;
            end
            REL: if (pressed) begin
                state_nxt = HELD;
            end else if (cnt_done) begin
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef INP_CAPTURE_FIFO_EN
    logic [DATA_W-1:0] mem [4];
    logic [1:0]        rptr, wptr;
    logic [2:0]        count;
    logic              pop, push;

    assign pop  = bus.inack && (count != 3'd0);
    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign push = capture && ((count != 3'd4) || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= live;
                wptr      <= wptr + 2'd1;
            end
            if (pop) rptr <= rptr + 2'd1;
            if (push && !pop)      count <= count + 3'd1;
            else if (pop && !push) count <= count - 3'd1;
            if (capture && !push) overrun <= 1'b1;
        end
    end

    assign bus.inpval   = mem[rptr];
    assign bus.inpvalid = (count != 3'd0);
`else
    logic [DATA_W-1:0] val_q;
    logic              valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            val_q   <= '0;
            valid_q <= 1'b0;
            overrun <= 1'b0;
        end else if (capture) begin
            if (!valid_q || bus.inack) begin
                val_q   <= live;
                valid_q <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (bus.inack) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.inpval   = val_q;
    assign bus.inpvalid = valid_q;
`endif
endmodule
